adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- SPI-slave model of the serial ADC; the responder end of the link the ADC master drives (cs_n, mosi, sclk in; miso out).
- Accepts 12-bit samples on an Avalon-ST sink, buffers them, and serves one per 16-bit frame on miso.
- Decodes the master's control word and reports it on an Avalon-ST source.
- Used as a synthesizable loopback/stimulus source for ADC-path bring-up and bench checking without the physical converter.

Parameters:
- DEPTH, 4, sample FIFO depth (power of 2, >=2)
- FRAME_BITS, 16, SPI frame length in clk edges

Ports:
- clk  input  1  SPI/system clock (the sclk domain); all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cs_n  input  1  frame select from master, active low
- mosi  input  1  control bit from master, sampled on rising clk while cs_n low
- miso  output  1  response bit to master, registered
- ast_sink_data  input  12  sample to serve
- ast_sink_valid  input  1  sample present
- ast_sink_ready  output  1  FIFO not full
- ast_source_data  output  16  received control word
- ast_source_valid  output  1  one-cycle pulse per completed frame
- ast_source_error  output  2  01 = underrun on this frame, 10 = truncated frame, 00 = ok
- channel  output  3  current channel address

Behaviour:
- Reset values: miso=0, ast_source_data=0, ast_source_valid=0, ast_source_error=0, channel=0, FIFO empty, ast_sink_ready=1, bit count=0, last_sample=0, state IDLE.
- Sink handshake: a sample is written on any edge with valid&&ready. ready = !full.
- States:
  - IDLE: cs_n high. miso holds tx[15].
  - SHIFT: cs_n low, count < FRAME_BITS.
  - HOLD: cs_n low, count == FRAME_BITS.
- Load, first edge with cs_n low in IDLE:
  - If FIFO non-empty: pop the head into last_sample.
  - If FIFO empty: reuse last_sample and set the sticky underrun flag.
  - tx = {1'b0, channel, sample[11:0]}.
  - miso presents tx[15] from the same edge. The edge also counts as bit 0: mosi shifts into rx[0], count=1, state SHIFT.
- SHIFT, each edge: rx = {rx[14:0], mosi}; tx shifts left and miso = next bit; count++.
- Bit timing: master sampling miso at edge k (k=0..15) after the load edge sees tx[15-k].
- Completion, edge where count reaches FRAME_BITS:
  - ast_source_data = rx, registered. ast_source_valid pulses 1 cycle on the following edge.
  - ast_source_error = 01 if underrun, else 00.
  - If rx[15] (WRITE) = 1: channel <= rx[12:10], effective from the next frame's response.
  - State HOLD.
- HOLD: further edges ignored; miso=0; no second valid.
- cs_n rising in HOLD: go to IDLE; clear underrun flag.
- cs_n rising in SHIFT (truncated frame):
  - Pulse ast_source_valid with error=10 and partial rx data.
  - Channel is not updated; the popped sample is consumed, not restored.
  - Go to IDLE.
- Simultaneous FIFO write and pop on the load edge:
  - Empty FIFO: the pop sees empty (underrun); the write lands normally.
  - Full FIFO: ready=0, so no write occurs.
- FIFO pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Reset mid-frame: everything returns to reset values immediately. The frame is lost with no valid pulse.
- Back-to-back frames: cs_n high for one edge is sufficient to re-arm.

Decomposition:
- Package adc_spi_pkg:
  - FRAME_BITS
  - field positions: WRITE_BIT=15, ADDR_MSB=12, ADDR_LSB=10
  - error codes: ERR_NONE, ERR_UNDERRUN, ERR_TRUNC
  - state enum: IDLE, SHIFT, HOLD
- One sub-module, sample_fifo: parameterised synchronous FIFO with push/pop/full/empty and async active-high reset. The shift/decode FSM stays in the top.

Test Plan:
- Single frame: push 12'hABC; drive a 16-edge frame with mosi = 16'h0000 → miso bit sequence 0,000,1010_1011_1100; ast_source_data=16'h0000, valid=1 pulse, error=00; channel stays 0.
- Channel write: frame with mosi = 16'h8C00 (WRITE=1, ADDR=3), then push 12'h123 and run a second frame → second response word 16'h3123; channel=3.
- Underrun: with FIFO empty and last_sample=12'h5A5, run a frame → response 16'h05A5 (channel 0); error=01; next frame after a push of 12'h001 → error=00.
- Full/backpressure: push DEPTH=4 samples → ready=0; fifth sample held; one frame pops one → ready=1 next edge; samples served in FIFO order.
- Truncated frame: raise cs_n after 7 edges → valid pulse, error=10, channel unchanged; next full frame serves the next FIFO entry.
- Async reset mid-frame: assert reset at edge 9 → miso=0, no valid, FIFO empty, ready=1; the first frame after release behaves as underrun with sample 0.

Source files
------------

// File: rtl/adc_spi_pkg.sv
`default_nettype none
//------------------------------------------------------------------------
// adc_spi_pkg : shared constants, field positions and enums for the
//               ADC SPI responder.                              rev 1.0
//------------------------------------------------------------------------
package adc_spi_pkg;

   localparam int FRAME_BITS  = 16;
   localparam int SAMPLE_BITS = 12;

   localparam int WRITE_BIT = 15;
   localparam int ADDR_MSB  = 12;
   localparam int ADDR_LSB  = 10;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_UNDERRUN = 2'b01,
      ERR_TRUNC    = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      HOLD  = 2'b10
   } state_e;

   // Response word layout: always-zero MSB, channel address, sample.
   function automatic logic [15:0] make_tx(input logic [2:0] ch,
                                           input logic [SAMPLE_BITS-1:0] sample);
      return {1'b0, ch, sample};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
//------------------------------------------------------------------------
// sample_fifo : small synchronous FIFO with show-ahead read data.
//                                                               rev 1.0
//------------------------------------------------------------------------
module sample_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
//------------------------------------------------------------------------
// adc_spi_responder : SPI-slave stand-in for the serial ADC, serving
//                     buffered samples and reporting control words. rev 1.0
//------------------------------------------------------------------------
module adc_spi_responder #(
   parameter int DEPTH      = 4,
   parameter int FRAME_BITS = adc_spi_pkg::FRAME_BITS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   input  logic [11:0] ast_sink_data,
   input  logic        ast_sink_valid,
   output logic        ast_sink_ready,
   output logic [15:0] ast_source_data,
   output logic        ast_source_valid,
   output logic [1:0]  ast_source_error,
   output logic [2:0]  channel
);

   import adc_spi_pkg::*;

   localparam int CNT_W = $clog2(FRAME_BITS) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

   state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0] rx_q, rx_d;
   logic [14:0] tx_q, tx_d;
   logic        miso_q, miso_d;
   logic [15:0] src_data_q, src_data_d;
   logic        src_valid_q, src_valid_d;
   logic [1:0]  src_err_q, src_err_d;
   logic [2:0]  channel_q, channel_d;
   logic [11:0] last_sample_q, last_sample_d;
   logic        underrun_q, underrun_d;
   logic        done_q, done_d;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [11:0] fifo_head, sample_sel;
   logic [15:0] rx_shift, tx_load;

   sample_fifo #(
      .WIDTH (12),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (ast_sink_data),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign fifo_push      = ast_sink_valid && !fifo_full;
   assign ast_sink_ready = !fifo_full;
   assign rx_shift       = {rx_q[14:0], mosi};
   assign sample_sel     = fifo_empty ? last_sample_q : fifo_head;
   assign tx_load        = make_tx(channel_q, sample_sel);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rx_d          = rx_q;
      tx_d          = tx_q;
      miso_d        = miso_q;
      src_data_d    = src_data_q;
      src_valid_d   = 1'b0;
      src_err_d     = src_err_q;
      channel_d     = channel_q;
      last_sample_d = last_sample_q;
      underrun_d    = underrun_q;
      done_d        = 1'b0;
      fifo_pop      = 1'b0;

      // Completed frames are reported one edge after the last bit lands.
      if (done_q) begin
         src_valid_d = 1'b1;
         src_data_d  = rx_q;
         src_err_d   = underrun_q ? ERR_UNDERRUN : ERR_NONE;
      end

      case (state_q)
         IDLE: begin
            // The response MSB is always zero, so idle miso is low.
            miso_d = 1'b0;
            cnt_d  = '0;
            if (!cs_n) begin
               fifo_pop      = !fifo_empty;
               last_sample_d = sample_sel;
               underrun_d    = underrun_q | fifo_empty;
               tx_d          = tx_load[14:0];
               miso_d        = tx_load[15];
               rx_d          = {15'b0, mosi};
               cnt_d         = CNT_W'(1);
               state_d       = SHIFT;
            end
         end

         SHIFT: begin
            if (cs_n) begin
               src_valid_d = 1'b1;
               src_data_d  = rx_q;
               src_err_d   = ERR_TRUNC;
               underrun_d  = 1'b0;
               miso_d      = 1'b0;
               cnt_d       = '0;
               state_d     = IDLE;
            end else begin
               rx_d   = rx_shift;
               tx_d   = {tx_q[13:0], 1'b0};
               miso_d = tx_q[14];
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  done_d  = 1'b1;
                  state_d = HOLD;
                  if (rx_shift[WRITE_BIT]) channel_d = rx_shift[ADDR_MSB:ADDR_LSB];
               end
            end
         end

         HOLD: begin
            miso_d = 1'b0;
            if (cs_n) begin
               underrun_d = 1'b0;
               cnt_d      = '0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rx_q          <= '0;
         tx_q          <= '0;
         miso_q        <= 1'b0;
         src_data_q    <= '0;
         src_valid_q   <= 1'b0;
         src_err_q     <= ERR_NONE;
         channel_q     <= '0;
         last_sample_q <= '0;
         underrun_q    <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rx_q          <= rx_d;
         tx_q          <= tx_d;
         miso_q        <= miso_d;
         src_data_q    <= src_data_d;
         src_valid_q   <= src_valid_d;
         src_err_q     <= src_err_d;
         channel_q     <= channel_d;
         last_sample_q <= last_sample_d;
         underrun_q    <= underrun_d;
         done_q        <= done_d;
      end
   end

   assign miso             = miso_q;
   assign ast_source_data  = src_data_q;
   assign ast_source_valid = src_valid_q;
   assign ast_source_error = src_err_q;
   assign channel          = channel_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------
// tb_adc_spi_responder : scoreboard bench for the ADC SPI responder. rev 1.0
//------------------------------------------------------------------------
module tb_adc_spi_responder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic [11:0] ast_sink_data;
   logic        ast_sink_valid;
   logic        ast_sink_ready;
   logic [15:0] ast_source_data;
   logic        ast_source_valid;
   logic [1:0]  ast_source_error;
   logic [2:0]  channel;

   always #5 clk = ~clk;

   adc_spi_responder #(
      .DEPTH      (DEPTH),
      .FRAME_BITS (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cs_n             (cs_n),
      .mosi             (mosi),
      .miso             (miso),
      .ast_sink_data    (ast_sink_data),
      .ast_sink_valid   (ast_sink_valid),
      .ast_sink_ready   (ast_sink_ready),
      .ast_source_data  (ast_source_data),
      .ast_source_valid (ast_source_valid),
      .ast_source_error (ast_source_error),
      .channel          (channel)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  err;
   } src_t;

   src_t        exp_q[$];
   logic [11:0] fifo_m[$];
   logic [11:0] last_m;
   logic [2:0]  ch_m;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every source pulse is matched against the oldest expected report.
   always @(negedge clk) begin
      if (ast_source_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(ast_source_valid), 32'd0);
         end else begin
            src_t e;
            e = exp_q.pop_front();
            chk("src_data", 32'(ast_source_data), 32'(e.data));
            chk("src_err", 32'(ast_source_error), 32'(e.err));
         end
      end
   end

   task automatic push(input logic [11:0] d);
      logic room;
      room = (fifo_m.size() < DEPTH);
      ast_sink_data  = d;
      ast_sink_valid = 1'b1;
      chk("sink_ready", 32'(ast_sink_ready), 32'(room));
      @(posedge clk);
      @(negedge clk);
      ast_sink_valid = 1'b0;
      if (room) fifo_m.push_back(d);
   endtask

   task automatic run_frame(input logic [15:0] word, input int n, input int hold);
      logic [11:0] s;
      logic        und;
      logic [15:0] tx, got, mask;
      src_t        e;
      und = (fifo_m.size() == 0);
      if (und) s = last_m;
      else     s = fifo_m.pop_front();
      last_m = s;
      tx  = {1'b0, ch_m, s};
      got = '0;
      for (int j = 0; j < n; j++) begin
         cs_n = 1'b0;
         mosi = word[15-j];
         @(posedge clk);
         @(negedge clk);
         got[15-j] = miso;
      end
      mask = (n >= 16) ? 16'hFFFF : ~(16'hFFFF >> n);
      chk("miso_bits", 32'(got & mask), 32'(tx & mask));
      e.data = (n >= 16) ? word : (word >> (16 - n));
      e.err  = (n >= 16) ? (und ? 2'b01 : 2'b00) : 2'b10;
      exp_q.push_back(e);
      if (n >= 16 && word[15]) ch_m = word[12:10];
      for (int j = 0; j < hold; j++) begin
         mosi = ~mosi;
         @(posedge clk);
         @(negedge clk);
         chk("hold_miso", 32'(miso), 32'd0);
      end
      cs_n = 1'b1;
      mosi = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("channel", 32'(channel), 32'(ch_m));
      chk("ready_after", 32'(ast_sink_ready), 32'(fifo_m.size() < DEPTH));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b1;
      cs_n           = 1'b1;
      mosi           = 1'b0;
      ast_sink_data  = '0;
      ast_sink_valid = 1'b0;
      last_m         = '0;
      ch_m           = '0;
      repeat (2) @(negedge clk);
      chk("rst_miso", 32'(miso), 32'd0);
      chk("rst_valid", 32'(ast_source_valid), 32'd0);
      chk("rst_err", 32'(ast_source_error), 32'd0);
      chk("rst_data", 32'(ast_source_data), 32'd0);
      chk("rst_channel", 32'(channel), 32'd0);
      chk("rst_ready", 32'(ast_sink_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Single frame
      push(12'hABC);
      run_frame(16'h0000, 16, 2);

      // Channel write, then a frame carrying the new address
      run_frame(16'h8C00, 16, 0);
      push(12'h123);
      run_frame(16'h0000, 16, 0);

      // Underrun and recovery
      push(12'h5A5);
      run_frame(16'h8000, 16, 0);
      run_frame(16'h0000, 16, 0);
      push(12'h001);
      run_frame(16'h7FFF, 16, 0);

      // Fill to full, backpressure, drain in order
      for (int i = 0; i < DEPTH; i++) push(12'hA01 + 12'(i));
      chk("full_ready", 32'(ast_sink_ready), 32'd0);
      push(12'hA05);
      run_frame(16'h0000, 16, 1);
      push(12'hA05);

      // Truncated frame with a WRITE bit that must not take effect
      run_frame(16'h9C00, 7, 0);
      run_frame(16'h1234, 16, 0);
      run_frame(16'h5678, 16, 2);
      run_frame(16'h0F0F, 16, 0);

      // Asynchronous reset in the middle of a frame
      push(12'h111);
      push(12'h222);
      run_frame(16'h9400, 16, 0);
      for (int j = 0; j < 9; j++) begin
         cs_n = 1'b0;
         mosi = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      #1 reset = 1'b1;
      #1;
      chk("arst_miso", 32'(miso), 32'd0);
      chk("arst_valid", 32'(ast_source_valid), 32'd0);
      chk("arst_ready", 32'(ast_sink_ready), 32'd1);
      chk("arst_channel", 32'(channel), 32'd0);
      @(negedge clk);
      cs_n  = 1'b1;
      reset = 1'b0;
      fifo_m.delete();
      last_m = '0;
      ch_m   = '0;
      @(negedge clk);
      run_frame(16'h0000, 16, 0);

      repeat (4) @(negedge clk);
      chk("pending_reports", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
